// File: rtl/ram_arbiter.sv
// Two-requester (CPU / program loader) arbiter for a single-port synchronous RAM.
// Optional build macro RAM_ARB_LOADER_PRIO_EN: fixed loader priority instead of round-robin.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   win_q, win_d;     // winner of the access in flight: 1 = loader, 0 = CPU
  logic   we_q, we_d;       // write-select of the access in flight, used to zero rdata
  logic   arb_go;
  logic   pick_l;
  logic   grant_sel;

  assign arb_go = !hold && (c_req || l_req);

`ifdef RAM_ARB_LOADER_PRIO_EN
  assign pick_l = l_req;
`else
  logic last_q;             // last winner: 1 = loader

  // A tie goes to whoever did not win last; a lone request always wins.
  assign pick_l = l_req && (!c_req || !last_q);

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b1;
    else if (grant_sel)
      last_q <= pick_l;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    grant_sel = 1'b0;
    c_gnt     = 1'b0;
    c_ack     = 1'b0;
    l_gnt     = 1'b0;
    l_ack     = 1'b0;
    rdata     = '0;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state_q)
      IDLE: begin
        if (arb_go) begin
          state_d   = ACCESS;
          win_d     = pick_l;
          grant_sel = 1'b1;
        end
      end

      ACCESS: begin
        ram_ce  = 1'b1;
        state_d = RESP;
        if (win_q) begin
          l_gnt     = 1'b1;
          ram_we    = l_we;
          ram_addr  = l_addr;
          ram_wdata = l_wdata;
          we_d      = l_we;
        end else begin
          c_gnt     = 1'b1;
          ram_we    = c_we;
          ram_addr  = c_addr;
          ram_wdata = c_wdata;
          we_d      = c_we;
        end
      end

      RESP: begin
        if (win_q) l_ack = 1'b1;
        else       c_ack = 1'b1;
        rdata = we_q ? '0 : ram_rdata;
        // Re-arbitrating here keeps back-to-back traffic at one access per two cycles.
        if (arb_go) begin
          state_d   = ACCESS;
          win_d     = pick_l;
          grant_sel = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle vector table plus a back-to-back tie sequence.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst, hold;
  logic       c_req, c_we, l_req, l_we;
  logic [3:0] c_addr, l_addr;
  logic [7:0] c_wdata, l_wdata;
  logic       c_gnt, c_ack, l_gnt, l_ack;
  logic [7:0] rdata;
  logic       ram_ce, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_ack(l_ack),
    .rdata(rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Observed bundle: {c_gnt, c_ack, l_gnt, l_ack, ram_ce, ram_we, ram_addr, ram_wdata, rdata}
  logic [25:0] obs;
  assign obs = {c_gnt, c_ack, l_gnt, l_ack, ram_ce, ram_we, ram_addr, ram_wdata, rdata};

  typedef struct {
    logic        rst, hold;
    logic        c_req, c_we;
    logic [3:0]  c_addr;
    logic [7:0]  c_wdata;
    logic        l_req, l_we;
    logic [3:0]  l_addr;
    logic [7:0]  l_wdata;
    logic [7:0]  ram_rdata;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [25:0] xp(input logic cg, input logic ca, input logic lg, input logic la,
                                     input logic ce, input logic we, input logic [3:0] addr,
                                     input logic [7:0] wd, input logic [7:0] rd);
    return {cg, ca, lg, la, ce, we, addr, wd, rd};
  endfunction

  function automatic vec_t mk(input logic r, input logic h,
                              input logic cr, input logic cw, input logic [3:0] ca, input logic [7:0] cd,
                              input logic lr, input logic lw, input logic [3:0] la, input logic [7:0] ld,
                              input logic [7:0] rr, input logic [25:0] e);
    vec_t v;
    v.rst = r; v.hold = h;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.l_req = lr; v.l_we = lw; v.l_addr = la; v.l_wdata = ld;
    v.ram_rdata = rr; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; hold = v.hold;
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
    l_req = v.l_req; l_we = v.l_we; l_addr = v.l_addr; l_wdata = v.l_wdata;
    ram_rdata = v.ram_rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] z;
    logic [3:0]  exp_h;
    z = '0;

    // Each row is one clock cycle; exp is what the outputs must show during that cycle.
    tbl.push_back(mk(1,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h00, z));                              // reset state
    tbl.push_back(mk(0,0, 1,0,4'h3,8'hAA, 0,0,4'h0,8'h00, 8'h5A, z));                              // CPU read request
    tbl.push_back(mk(0,0, 1,0,4'h3,8'hAA, 0,0,4'h0,8'h00, 8'h5A, xp(1,0,0,0,1,0,4'h3,8'hAA,8'h00)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h5A, xp(0,1,0,0,0,0,4'h0,8'h00,8'h5A)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h5A, z));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 1,1,4'hF,8'hC3, 8'h77, z));                              // loader write
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 1,1,4'hF,8'hC3, 8'h77, xp(0,0,1,0,1,1,4'hF,8'hC3,8'h00)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h77, xp(0,0,0,1,0,0,4'h0,8'h00,8'h00)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h77, z));
    tbl.push_back(mk(0,0, 1,0,4'h5,8'h00, 0,0,4'h0,8'h00, 8'h11, z));                              // hold raised at grant
    tbl.push_back(mk(0,1, 1,0,4'h5,8'h00, 1,0,4'h6,8'h00, 8'h11, xp(1,0,0,0,1,0,4'h5,8'h00,8'h00)));
    tbl.push_back(mk(0,1, 0,0,4'h0,8'h00, 1,0,4'h6,8'h00, 8'h22, xp(0,1,0,0,0,0,4'h0,8'h00,8'h22)));
    tbl.push_back(mk(0,1, 0,0,4'h0,8'h00, 1,0,4'h6,8'h00, 8'h22, z));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 1,0,4'h6,8'h00, 8'h22, z));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 1,0,4'h6,8'h00, 8'h22, xp(0,0,1,0,1,0,4'h6,8'h00,8'h00)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h33, xp(0,0,0,1,0,0,4'h0,8'h00,8'h33)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h33, z));
    tbl.push_back(mk(0,0, 1,0,4'h9,8'h00, 0,0,4'h0,8'h00, 8'h44, z));                              // reset mid-access
    tbl.push_back(mk(1,0, 1,0,4'h9,8'h00, 0,0,4'h0,8'h00, 8'h44, xp(1,0,0,0,1,0,4'h9,8'h00,8'h00)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h44, z));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h44, z));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 1,0,4'h2,8'h00, 8'h55, z));                              // lone loader after reset
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 1,0,4'h2,8'h00, 8'h55, xp(0,0,1,0,1,0,4'h2,8'h00,8'h00)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h55, xp(0,0,0,1,0,0,4'h0,8'h00,8'h55)));
    tbl.push_back(mk(0,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h55, z));

    drive(mk(1,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h00, z));
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end

    // Both requesters held high after reset: grants every other cycle, acks in between.
    @(negedge clk);
    drive(mk(1,0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h00, z));
    @(negedge clk);
    drive(mk(0,0, 1,0,4'h1,8'h00, 1,0,4'h2,8'h00, 8'h66, z));
    #1;
    check("tie_idle", 32'({c_gnt, l_gnt, c_ack, l_ack}), 32'h0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      int  k;
      logic loader_wins;
      @(negedge clk);
      #1;
      k = (cyc % 2 == 1) ? (cyc - 1) / 2 : (cyc - 2) / 2;
`ifdef RAM_ARB_LOADER_PRIO_EN
      loader_wins = 1'b1;
`else
      loader_wins = (k % 2 == 1);
`endif
      // exp_h = {c_gnt, l_gnt, c_ack, l_ack}
      if (cyc % 2 == 1) exp_h = loader_wins ? 4'b0100 : 4'b1000;
      else              exp_h = loader_wins ? 4'b0001 : 4'b0010;
      check($sformatf("tie_cyc%0d", cyc), 32'({c_gnt, l_gnt, c_ack, l_ack}), 32'(exp_h));
      check($sformatf("gnt_onehot_cyc%0d", cyc), 32'(c_gnt & l_gnt), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port hold  input  1  blocks new grants while high; an in-flight access still completes.
REQ-006 SHALL have ports c_req/c_we  input  1 each  CPU request and write-select.
REQ-007 SHALL have ports c_addr/c_wdata  input  ADDR_W/DATA_W  CPU address and write data.
REQ-008 SHALL have ports c_gnt/c_ack  output  1 each  CPU grant pulse and completion pulse.
REQ-009 SHALL have ports l_req/l_we/l_addr/l_wdata/l_gnt/l_ack, with the same directions and widths, for the program-loader requester.
REQ-010 SHALL have port rdata  output  DATA_W  read data, valid only while c_ack or l_ack is high.
REQ-011 SHALL have ports ram_ce/ram_we  output  1 each  RAM chip-enable and write-enable, both active-high.
REQ-012 SHALL have ports ram_addr/ram_wdata  output  ADDR_W/DATA_W  RAM address and write data.
REQ-013 SHALL have port ram_rdata  input  DATA_W  RAM read data, valid one cycle after a ram_ce cycle.

Function
REQ-014 SHALL implement three states: IDLE, ACCESS, RESP.
REQ-015 In IDLE with hold=0 and any req high, SHALL select a winner and enter ACCESS on the next edge; otherwise SHALL remain in IDLE.
REQ-016 In ACCESS, SHALL assert ram_ce, drive ram_we/ram_addr/ram_wdata from the winner's inputs, and assert the winner's gnt, all for exactly one cycle.
REQ-017 In RESP, SHALL assert the winner's ack for one cycle; for a read, rdata SHALL equal ram_rdata; for a write, rdata SHALL be 0.
REQ-018 From RESP with hold=0 and any req high, SHALL arbitrate again and enter ACCESS directly (back-to-back throughput: one access per 2 cycles); otherwise SHALL go to IDLE.
REQ-019 Latency, req high in IDLE to ack: exactly 2 cycles.
REQ-020 Arbitration SHALL be round-robin, using a last-winner register: when both req are high, the requester that did not win last SHALL be granted.
REQ-021 When a single req is high, that requester SHALL win regardless of the last winner.
REQ-022 Requesters SHALL hold req, we, addr and wdata stable until their gnt; the arbiter SHALL sample the payload only in ACCESS.
REQ-023 A req dropped before grant SHALL be treated as withdrawn, with no gnt and no ack.
REQ-024 Asserting hold during ACCESS or RESP SHALL NOT abort that access; its ack SHALL still occur.
REQ-025 Outside ACCESS, ram_ce, ram_we, ram_addr and ram_wdata SHALL be 0.
REQ-026 At most one of c_gnt/l_gnt, and at most one of c_ack/l_ack, SHALL be high in any cycle.
REQ-027 An unreachable state encoding SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-028 While rst=1 at an edge, SHALL enter IDLE and set the last-winner register to "loader", so the CPU wins the first tie.
REQ-029 After reset, every output (gnt, ack, rdata, ram_*) SHALL be 0.
REQ-030 Reset asserted mid-access SHALL discard the access: no ack and no further ram_ce.

Configuration
REQ-031 With macro RAM_ARB_LOADER_PRIO_EN defined, SHALL use fixed priority: the loader wins every tie, the last-winner register is not used, and CPU starvation while l_req stays high is permitted.
REQ-032 Without RAM_ARB_LOADER_PRIO_EN, SHALL use round-robin per REQ-020.

Verification
REQ-033 Reset, then c_req=1, c_we=0, c_addr=3, ram_rdata=0x5A -> c_gnt in cycle 1, ram_ce=1, ram_addr=3, ram_we=0; c_ack in cycle 2 with rdata=0x5A.
REQ-034 l_req=1, l_we=1, l_addr=0xF, l_wdata=0xC3 -> one ram_ce cycle with ram_we=1, ram_addr=0xF, ram_wdata=0xC3; l_ack the next cycle with rdata=0.
REQ-035 Both req held high for 8 cycles after reset (macro undefined) -> grants C,L,C,L alternating, one ack every 2 cycles, never both gnt high at once.
REQ-036 Same stimulus with RAM_ARB_LOADER_PRIO_EN defined -> l_gnt on every grant and c_gnt never.
REQ-037 hold=1 raised in the cycle c_gnt is high -> c_ack still pulses next cycle; no new grant while hold=1, even with l_req=1; l_gnt one cycle after hold falls.
REQ-038 rst=1 in the ACCESS cycle of a read -> no ack follows, ram_ce=0 and all outputs 0 from the next cycle.
